// File: rtl/ode_euler_pkg.sv
// Shared definitions for the Euler step sequencer.
// State encoding and default counter widths.
package ode_euler_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int STEP_W_DEF = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_READY = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    REQ   = ST_REQ,
    WRITE = ST_WRITE,
    READY = ST_READY,
    FIN   = ST_FIN
  } seq_state_t;

endpackage

// File: rtl/euler_bound_counter.sv
// Saturating up-counter bounded by a captured limit.
// is_last flags count == limit-1; no wrap past it.
module euler_bound_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_async,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         is_last
);

  assign is_last = (count == limit - W'(1));

  // count register: clear wins, increment stops at the bound
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !is_last) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/euler_step_sequencer.sv
// Producer side of the Euler end-of-computation handshake.
// Walks rows x steps, emitting F (level), R, then D.
module euler_step_sequencer
  import ode_euler_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              rst_sync,
  input  logic              start,
  input  logic [ADDR_W-1:0] n_rows,
  input  logic [STEP_W-1:0] n_steps,
  input  logic              calc_ack,
  output logic              calc_req,
  output logic [ADDR_W-1:0] row_addr,
  output logic [STEP_W-1:0] step_idx,
  output logic              wr_en,
  output logic              final_flag,
  output logic              row_end,
  output logic              data_ready,
  output logic              busy,
  output logic              done
);

  seq_state_t        state;
  logic [ADDR_W-1:0] n_rows_q;
  logic [STEP_W-1:0] n_steps_q;
  logic              run_q;
  logic              row_last;
  logic              step_last;
  logic              go;
  logic              wrap;
  logic              row_clr;
  logic              row_inc;
  logic              step_clr;
  logic              step_inc;

  assign go = (state == IDLE) && start
           && (n_rows != '0) && (n_steps != '0);

  assign wrap = (state == READY) && row_last
             && !step_last;

  assign row_clr  = rst_sync || go || wrap;
  assign row_inc  = (state == READY) && !row_last;
  assign step_clr = rst_sync || go;
  assign step_inc = wrap;

  // F is high for every working state of the last step
  assign final_flag = run_q && step_last;

  euler_bound_counter #(.W(ADDR_W)) u_rows (
    .clk       (clk),
    .rst_async (rst_async),
    .clr       (row_clr),
    .inc       (row_inc),
    .limit     (n_rows_q),
    .count     (row_addr),
    .is_last   (row_last)
  );

  euler_bound_counter #(.W(STEP_W)) u_steps (
    .clk       (clk),
    .rst_async (rst_async),
    .clr       (step_clr),
    .inc       (step_inc),
    .limit     (n_steps_q),
    .count     (step_idx),
    .is_last   (step_last)
  );

  // sequencing FSM with registered handshake outputs
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      state      <= IDLE;
      n_rows_q   <= '0;
      n_steps_q  <= '0;
      run_q      <= 1'b0;
      calc_req   <= 1'b0;
      wr_en      <= 1'b0;
      row_end    <= 1'b0;
      data_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (rst_sync) begin
      state      <= IDLE;
      run_q      <= 1'b0;
      calc_req   <= 1'b0;
      wr_en      <= 1'b0;
      row_end    <= 1'b0;
      data_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wr_en      <= 1'b0;
      row_end    <= 1'b0;
      data_ready <= 1'b0;
      done       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            n_rows_q  <= n_rows;
            n_steps_q <= n_steps;
            run_q     <= 1'b1;
            calc_req  <= 1'b1;
            busy      <= 1'b1;
            state     <= REQ;
          end else if (start) begin
            done  <= 1'b1;
            busy  <= 1'b1;
            state <= FIN;
          end
        end
        REQ: begin
          if (calc_ack) begin
            calc_req <= 1'b0;
            wr_en    <= 1'b1;
            row_end  <= row_last;
            state    <= WRITE;
          end
        end
        WRITE: begin
          data_ready <= row_end;
          state      <= READY;
        end
        READY: begin
          if (row_last && step_last) begin
            run_q <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            calc_req <= 1'b1;
            state    <= REQ;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_euler_step_sequencer.sv
// Directed bench for euler_step_sequencer.
// Ack responder, event monitor and F/R/D end-detect model.
module tb_euler_step_sequencer;

  logic        clk = 1'b0;
  logic        rst_async;
  logic        rst_sync;
  logic        start;
  logic [7:0]  n_rows;
  logic [15:0] n_steps;
  logic        calc_ack;
  logic        calc_req;
  logic [7:0]  row_addr;
  logic [15:0] step_idx;
  logic        wr_en;
  logic        final_flag;
  logic        row_end;
  logic        data_ready;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  int cyc, ack_dly, wait_cnt, exp_last;
  bit spur;
  int wr_cnt, re_cnt, dr_cnt, done_cnt;
  int req_cyc, busy_cyc, ff_cyc;
  int ord_err, ff_bad;
  int first_ff, first_re, first_dr, first_done;
  bit prev_re;
  int ed_st, ed_cnt;
  int addr_log[$];

  euler_step_sequencer dut (
    .clk        (clk),
    .rst_async  (rst_async),
    .rst_sync   (rst_sync),
    .start      (start),
    .n_rows     (n_rows),
    .n_steps    (n_steps),
    .calc_ack   (calc_ack),
    .calc_req   (calc_req),
    .row_addr   (row_addr),
    .step_idx   (step_idx),
    .wr_en      (wr_en),
    .final_flag (final_flag),
    .row_end    (row_end),
    .data_ready (data_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d",
               tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    cyc = 0; wait_cnt = 0;
    wr_cnt = 0; re_cnt = 0; dr_cnt = 0;
    done_cnt = 0; req_cyc = 0; busy_cyc = 0;
    ff_cyc = 0; ord_err = 0; ff_bad = 0;
    first_ff = -1; first_re = -1;
    first_dr = -1; first_done = -1;
    prev_re = 1'b0; ed_st = 0; ed_cnt = 0;
    addr_log.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"},
        {25'd0, calc_req, wr_en, final_flag,
         row_end, data_ready, busy, done}, 0);
    chk({tag, "_row"}, 32'(row_addr), 0);
    chk({tag, "_step"}, 32'(step_idx), 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cyc++;
    if (calc_req) req_cyc++;
    if (wr_en) begin
      wr_cnt++;
      addr_log.push_back(int'(row_addr));
    end
    if (row_end) begin
      re_cnt++;
      if (first_re < 0) first_re = cyc;
      if (final_flag !==
          (int'(step_idx) == exp_last))
        ff_bad++;
    end
    if (data_ready) begin
      dr_cnt++;
      if (first_dr < 0) first_dr = cyc;
      if (!prev_re) ord_err++;
    end
    if (prev_re && !data_ready) ord_err++;
    prev_re = row_end;
    if (final_flag) begin
      ff_cyc++;
      if (first_ff < 0) first_ff = cyc;
    end
    if (done) begin
      done_cnt++;
      if (first_done < 0) first_done = cyc;
    end
    case (ed_st)
      0: if (final_flag) ed_st = 1;
      1: if (!final_flag) ed_st = 0;
         else if (row_end) ed_st = 2;
      2: if (data_ready) begin
           ed_cnt++;
           ed_st = 3;
         end else ed_st = 0;
      default: ;
    endcase
    if (calc_req) wait_cnt++;
    else wait_cnt = 0;
    calc_ack = calc_req ? (wait_cnt > ack_dly)
                        : spur;
    start = spur && busy;
  endtask

  task automatic run(input int nr, input int ns,
                     input int dly, input bit sp,
                     input string tag);
    bit to;
    clr_mon();
    ack_dly = dly; spur = sp;
    exp_last = ns - 1;
    n_rows = 8'(nr); n_steps = 16'(ns);
    start = 1'b1;
    to = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    spur = 1'b0; start = 1'b0; calc_ack = 1'b0;
    chk({tag, "_timeout"}, 32'(to), 0);
    cycle();
    chk({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    bit hit;
    rst_async = 1'b1; rst_sync = 1'b0;
    start = 1'b0; calc_ack = 1'b0;
    n_rows = '0; n_steps = '0;
    ack_dly = 0; spur = 1'b0; exp_last = -1;
    clr_mon();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    rst_async = 1'b0;
    @(posedge clk); #1;

    // 1: 3x2, ack one cycle late
    run(3, 2, 1, 1'b0, "t1");
    chk("t1_wr", wr_cnt, 6);
    chk("t1_re", re_cnt, 2);
    chk("t1_dr", dr_cnt, 2);
    chk("t1_ord", ord_err, 0);
    chk("t1_ffre", ff_bad, 0);
    chk("t1_ffcyc", ff_cyc, 12);
    chk("t1_req", req_cyc, 12);
    chk("t1_busy", busy_cyc, 25);
    chk("t1_done", done_cnt, 1);

    // 2: 1x1, zero-wait ack
    run(1, 1, 0, 1'b0, "t2");
    chk("t2_ff_at", first_ff, 1);
    chk("t2_re_at", first_re, 2);
    chk("t2_dr_at", first_dr, 3);
    chk("t2_done_at", first_done, 4);
    chk("t2_busy", busy_cyc, 4);
    chk("t2_ffcyc", ff_cyc, 3);

    // 3: zero-count launches
    run(0, 5, 0, 1'b0, "t3a");
    chk("t3a_done_at", first_done, 1);
    chk("t3a_act",
        req_cyc + wr_cnt + ff_cyc + re_cnt + dr_cnt, 0);
    chk("t3a_busy", busy_cyc, 1);
    run(4, 0, 0, 1'b0, "t3b");
    chk("t3b_done_at", first_done, 1);
    chk("t3b_act",
        req_cyc + wr_cnt + ff_cyc + re_cnt + dr_cnt, 0);

    // 4: spurious start/ack while busy, 4x2
    run(4, 2, 1, 1'b1, "t4");
    chk("t4_wr", wr_cnt, 8);
    chk("t4_done", done_cnt, 1);
    chk("t4_busy", busy_cyc, 33);
    chk("t4_nlog", addr_log.size(), 8);
    for (int i = 0; i < addr_log.size() && i < 8; i++)
      chk($sformatf("t4_addr%0d", i),
          addr_log[i], i % 4);
    repeat (3) cycle();
    chk("t4_quiet", busy_cyc + done_cnt, 34);

    // 5: async abort in REQ of step 1 row 2, 4x3
    clr_mon();
    ack_dly = 1; exp_last = 2;
    n_rows = 8'd4; n_steps = 16'd3;
    start = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      cycle();
      if (calc_req && step_idx == 16'd1
          && row_addr == 8'd2) begin
        hit = 1'b1;
        break;
      end
    end
    chk("t5_hit", 32'(hit), 1);
    chk("t5_wr", wr_cnt, 6);
    #2 rst_async = 1'b1;
    #1 chk_zero("t5_abort");
    @(posedge clk); #1;
    rst_async = 1'b0; calc_ack = 1'b0;
    clr_mon();
    repeat (4) cycle();
    chk("t5_nodone", done_cnt, 0);
    chk("t5_nobusy", busy_cyc, 0);
    run(2, 1, 0, 1'b0, "t5b");
    chk("t5b_wr", wr_cnt, 2);
    chk("t5b_re", re_cnt, 1);
    chk("t5b_done", done_cnt, 1);

    // 6: rst_sync beats start, then 5x3 end-detect
    n_rows = 8'd5; n_steps = 16'd3;
    start = 1'b1; rst_sync = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rst_sync = 1'b0;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_req", 32'(calc_req), 0);
    @(posedge clk); #1;
    chk("t6_busy2", 32'(busy), 0);
    run(5, 3, 2, 1'b0, "t6");
    chk("t6_ed", ed_cnt, 1);
    chk("t6_wr", wr_cnt, 15);
    chk("t6_re", re_cnt, 3);
    chk("t6_ord", ord_err, 0);
    chk("t6_ffre", ff_bad, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
